// File: rtl/inst_fetch_pkg.sv
// Shared fetch-side definitions: bus widths, ROM enable levels, reset vector, alignment helper.
// Imported by the fetch top and the IF/ID pipeline register.
package inst_fetch_pkg;

    localparam int          INST_ADDR_BUS_W  = 32;
    localparam int          INST_BUS_W       = 32;
    localparam logic [31:0] ZERO_WORD        = 32'h0000_0000;
    localparam logic        CHIP_ENABLE      = 1'b1;
    localparam logic        CHIP_DISABLE     = 1'b0;
    localparam logic [31:0] RESET_VECTOR_DEF = 32'h0000_0000;

    function automatic logic is_misaligned(input logic [1:0] addr_lsb);
        return addr_lsb != 2'b00;
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: one-edge capture of fetch PC, instruction and misaligned flag.
// Flush clears; IF stall with ID running inserts a bubble; ID stall holds the entry.
module if_id_reg #(
    parameter int ADDR_W = 32,
    parameter int INST_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              stall_if,
    input  logic              stall_id,
    input  logic [ADDR_W-1:0] cap_pc,
    input  logic [INST_W-1:0] cap_inst,
    input  logic              cap_exc,
    output logic [ADDR_W-1:0] id_pc_o,
    output logic [INST_W-1:0] id_inst_o,
    output logic              id_fetch_exc_o
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            id_pc_o        <= '0;
            id_inst_o      <= '0;
            id_fetch_exc_o <= 1'b0;
        end else if (flush || (stall_if && !stall_id)) begin
            id_pc_o        <= '0;
            id_inst_o      <= '0;
            id_fetch_exc_o <= 1'b0;
        end else if (!stall_id) begin
            id_pc_o        <= cap_pc;
            id_inst_o      <= cap_inst;
            id_fetch_exc_o <= cap_exc;
        end
    end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch: PC, ROM enable/address, pending-branch capture and IF/ID register.
// ROM answers same cycle, IF/ID one edge later; stall_if holds PC, stall_id holds IF/ID.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter int                ADDR_W       = INST_ADDR_BUS_W,
    parameter int                INST_W       = INST_BUS_W,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = ADDR_W'(RESET_VECTOR_DEF)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_if,
    input  logic              stall_id,
    input  logic              flush,
    input  logic [ADDR_W-1:0] new_pc,
    input  logic              branch_flag_i,
    input  logic [ADDR_W-1:0] branch_target_i,
    input  logic [INST_W-1:0] inst_i,
    output logic              rom_ce_o,
    output logic [ADDR_W-1:0] pc_o,
    output logic [ADDR_W-1:0] id_pc_o,
    output logic [INST_W-1:0] id_inst_o,
    output logic              id_fetch_exc_o
);

    logic              ce_q;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              pend_vld_q, pend_vld_d;
    logic [ADDR_W-1:0] pend_tgt_q, pend_tgt_d;
    logic              misaligned;
    logic [ADDR_W-1:0] cap_pc;
    logic [INST_W-1:0] cap_inst;
    logic              cap_exc;

    assign misaligned = is_misaligned(pc_q[1:0]);
    assign rom_ce_o   = (ce_q == CHIP_ENABLE && !misaligned) ? CHIP_ENABLE : CHIP_DISABLE;
    assign pc_o       = pc_q;

    // Before the first fetch cycle the IF/ID entry must stay empty.
    assign cap_pc   = (ce_q == CHIP_ENABLE) ? pc_q : '0;
    assign cap_inst = (rom_ce_o == CHIP_ENABLE) ? inst_i : INST_W'(ZERO_WORD);
    assign cap_exc  = (ce_q == CHIP_ENABLE) && misaligned;

    always_comb begin
        pc_d       = pc_q;
        pend_vld_d = pend_vld_q;
        pend_tgt_d = pend_tgt_q;
        if (ce_q == CHIP_ENABLE) begin
            if (flush) begin
                pc_d       = new_pc;
                pend_vld_d = 1'b0;
                pend_tgt_d = '0;
            end else if (!misaligned) begin
                // A misaligned PC is parked until the exception handler redirects via flush.
                if (stall_if) begin
                    if (branch_flag_i) begin
                        pend_vld_d = 1'b1;
                        pend_tgt_d = branch_target_i;
                    end
                end else if (pend_vld_q) begin
                    pc_d       = pend_tgt_q;
                    pend_vld_d = 1'b0;
                end else if (branch_flag_i) begin
                    pc_d = branch_target_i;
                end else begin
                    pc_d = pc_q + ADDR_W'(4);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ce_q       <= CHIP_DISABLE;
            pc_q       <= RESET_VECTOR;
            pend_vld_q <= 1'b0;
            pend_tgt_q <= '0;
        end else begin
            ce_q       <= CHIP_ENABLE;
            pc_q       <= pc_d;
            pend_vld_q <= pend_vld_d;
            pend_tgt_q <= pend_tgt_d;
        end
    end

    if_id_reg #(
        .ADDR_W (ADDR_W),
        .INST_W (INST_W)
    ) u_if_id_reg (
        .clk            (clk),
        .rst            (rst),
        .flush          (flush),
        .stall_if       (stall_if),
        .stall_id       (stall_id),
        .cap_pc         (cap_pc),
        .cap_inst       (cap_inst),
        .cap_exc        (cap_exc),
        .id_pc_o        (id_pc_o),
        .id_inst_o      (id_inst_o),
        .id_fetch_exc_o (id_fetch_exc_o)
    );

endmodule
